// File: rtl/frame_mem_arbiter.sv
// Frame memory arbiter: display reads always win the single RAM port,
// processor loads/stores wait in a one-entry slot for a free cycle.
module frame_mem_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 10003,
    parameter int WAIT_W    = 16
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    output logic [WAIT_W-1:0] cpu_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RDWAIT
    } state_e;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    state_e              state_q;
    logic                slot_we_q;
    logic                slot_oor_q;
    logic [ADDR_W-1:0]   slot_addr_q;
    logic [DATA_W-1:0]   slot_wdata_q;
    logic                disp_valid_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                cpu_rvalid_q;
    logic                cpu_err_q;
    logic [WAIT_W-1:0]   cpu_stall_q;
    logic                addr_oor;

    assign addr_oor   = {1'b0, cpu_addr} >= LIMIT;
    assign cpu_ready  = (state_q == IDLE);
    assign disp_data  = ram_rdata;
    assign disp_valid = disp_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_err    = cpu_err_q;
    assign cpu_stall  = cpu_stall_q;
    assign ram_wdata  = slot_wdata_q;

    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        if (disp_req) begin
            ram_addr = disp_addr;
        end else if (state_q == PEND) begin
            ram_addr = slot_addr_q;
            ram_we   = slot_we_q && !slot_oor_q;
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            slot_we_q    <= 1'b0;
            slot_oor_q   <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            disp_valid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_stall_q  <= '0;
        end else begin
            disp_valid_q <= disp_req;
            cpu_rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        slot_we_q    <= cpu_we;
                        slot_oor_q   <= addr_oor;
                        slot_addr_q  <= cpu_addr;
                        slot_wdata_q <= cpu_wdata;
                        cpu_stall_q  <= '0;
                        state_q      <= PEND;
                    end
                end
                PEND: begin
                    if (disp_req) begin
                        if (cpu_stall_q != '1)
                            cpu_stall_q <= cpu_stall_q + WAIT_W'(1);
                    end else begin
                        if (slot_oor_q)
                            cpu_err_q <= 1'b1;
                        state_q <= slot_we_q ? IDLE : RDWAIT;
                    end
                end
                RDWAIT: begin
                    // out-of-range reads return zero, RAM output ignored
                    cpu_rdata_q  <= slot_oor_q ? '0 : ram_rdata;
                    cpu_rvalid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter with a behavioural frame RAM.
// A second instance with a 4-bit stall counter covers saturation.
module tb_frame_mem_arbiter;

    typedef struct packed {
        logic [7:0] d;
        int         due;
    } rd_t;

    typedef struct packed {
        logic [13:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 0;
    logic        rst = 0;
    logic        disp_req = 0;
    logic [13:0] disp_addr = 0;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_valid = 0;
    logic        cpu_ready;
    logic        cpu_we = 0;
    logic [13:0] cpu_addr = 0;
    logic [7:0]  cpu_wdata = 0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_err;
    logic [15:0] cpu_stall;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 0;

    logic        d2_req = 0;
    logic [7:0]  d2_data;
    logic        d2_valid;
    logic        c2_valid = 0;
    logic        c2_ready;
    logic [7:0]  c2_rdata;
    logic        c2_rvalid;
    logic        c2_err;
    logic [3:0]  c2_stall;
    logic [13:0] r2_addr;
    logic        r2_we;
    logic [7:0]  r2_wdata;
    logic [7:0]  r2_rdata = 0;

    logic [7:0]  mem [16384];
    logic [7:0]  exp_mem [16384];
    rd_t         rd_q[$];
    wr_t         wr_q[$];
    logic [7:0]  dq[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          disp_mon = 1;

    always #5 clk = ~clk;

    frame_mem_arbiter u_dut (
        .vga_clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
        .cpu_stall(cpu_stall), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    frame_mem_arbiter #(.WAIT_W(4)) u_sat (
        .vga_clk(clk), .rst(rst),
        .disp_req(d2_req), .disp_addr(14'h0),
        .disp_data(d2_data), .disp_valid(d2_valid),
        .cpu_valid(c2_valid), .cpu_ready(c2_ready),
        .cpu_we(1'b1), .cpu_addr(14'h0020),
        .cpu_wdata(8'h33), .cpu_rdata(c2_rdata),
        .cpu_rvalid(c2_rvalid), .cpu_err(c2_err),
        .cpu_stall(c2_stall), .ram_addr(r2_addr),
        .ram_we(r2_we), .ram_wdata(r2_wdata),
        .ram_rdata(r2_rdata)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rd_t r;
        if (cpu_rvalid) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rvalid", 1, 0);
            end else begin
                r = rd_q.pop_front();
                chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, r.d});
                if (r.due != 0) chk("rvalid_cycle", cyc, r.due);
            end
        end
    end

    always @(negedge clk) begin
        wr_t w;
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_ram_we", {18'h0, ram_addr}, 32'hFFFF);
            end else begin
                w = wr_q.pop_front();
                chk("ram_we_addr", {18'h0, ram_addr}, {18'h0, w.a});
                chk("ram_we_data", {24'h0, ram_wdata}, {24'h0, w.d});
            end
        end
    end

    always @(negedge clk) begin
        if (disp_valid && disp_mon) begin
            if (dq.size() == 0) chk("unexpected_disp_valid", 1, 0);
            else chk("disp_data", {24'h0, disp_data}, {24'h0, dq.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input logic we, input logic [13:0] a,
                        input logic [7:0] d, output int acc);
        int n = 0;
        cpu_valid = 1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        while (!cpu_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!cpu_ready) chk("xfer_timeout", 0, 1);
        acc = cyc;
        tick(1);
        cpu_valid = 0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] d);
        int acc;
        wr_q.push_back('{a: a, d: d});
        exp_mem[a] = d;
        xfer(1, a, d, acc);
    endtask

    task automatic rd(input logic [13:0] a, input logic [7:0] e,
                      output int acc);
        xfer(0, a, 8'h00, acc);
        rd_q.push_back('{d: e, due: acc + 3});
    endtask

    initial begin
        int acc;
        int acc2;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'(i) ^ 8'hA5;
            exp_mem[i] = 8'(i) ^ 8'hA5;
        end
        tick(3);
        rst = 1;
        @(negedge clk);
        chk("rst_ready", {31'h0, cpu_ready}, 1);
        chk("rst_ram_we", {31'h0, ram_we}, 0);
        chk("rst_status", {disp_valid, cpu_rvalid, cpu_rdata,
                           cpu_err, cpu_stall}, 0);
        tick(1);

        wr(14'h0003, 8'h5A);
        tick(2);
        rd(14'h0003, 8'h5A, acc);
        tick(3);
        chk("stall_uncontended", {16'h0, cpu_stall}, 0);

        rd(14'h0004, 8'hA1, acc);
        tick(2);
        chk("b2b_ready", {31'h0, cpu_ready}, 1);
        wr_q.push_back('{a: 14'h0005, d: 8'h77});
        exp_mem[5] = 8'h77;
        xfer(1, 14'h0005, 8'h77, acc2);
        chk("b2b_accept", acc2, acc + 3);
        tick(2);
        rd(14'h0005, 8'h77, acc);
        tick(4);

        wr(14'h0100, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            disp_req = 1;
            disp_addr = 14'h0200 + 14'(i);
            dq.push_back(8'(i) ^ 8'hA5);
            tick(1);
        end
        disp_req = 0;
        @(negedge clk);
        chk("cont_ram_we", {31'h0, ram_we}, 1);
        chk("cont_ram_addr", {18'h0, ram_addr}, 32'h0100);
        tick(2);
        chk("cont_stall", {16'h0, cpu_stall}, 20);
        rd(14'h0100, 8'hFF, acc);
        tick(4);

        xfer(1, 14'd10003, 8'h12, acc);
        tick(2);
        chk("oor_err_wr", {31'h0, cpu_err}, 1);
        rd(14'h3FFF, 8'h00, acc);
        tick(4);
        rd(14'h0003, 8'h5A, acc);
        tick(4);
        chk("oor_err_sticky", {31'h0, cpu_err}, 1);

        disp_mon = 0;
        disp_req = 1;
        xfer(1, 14'h0010, 8'h99, acc);
        tick(3);
        #2;
        rst = 0;
        #1;
        chk("rst_mid_ready", {31'h0, cpu_ready}, 1);
        chk("rst_mid_err", {31'h0, cpu_err}, 0);
        disp_req = 0;
        #1;
        chk("rst_mid_ram_we", {31'h0, ram_we}, 0);
        tick(1);
        rst = 1;
        @(negedge clk);
        chk("rel_ram_we", {31'h0, ram_we}, 0);
        tick(6);
        rd(14'h0010, 8'hB5, acc);
        tick(4);

        c2_valid = 1;
        tick(1);
        c2_valid = 0;
        d2_req = 1;
        tick(30);
        chk("sat_stall", {28'h0, c2_stall}, 15);
        d2_req = 0;
        @(negedge clk);
        chk("sat_ram_we", {31'h0, r2_we}, 1);
        chk("sat_ram_addr", {18'h0, r2_addr}, 32'h0020);
        tick(1);
        chk("sat_ready", {31'h0, c2_ready}, 1);

        tick(4);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
Arbitrates the single-port grayscale frame memory between the VGA display reader (pixel fetch, 1 byte/pixel) and the processor load/store port.
- Display reads have absolute priority and are never delayed.
- Processor accesses are buffered in a one-entry slot and issued on the next free cycle, with a valid/ready request handshake and a read-data valid pulse.
- Sits between the pixel printer, the processor memory-mapped I/O decoder and the frame RAM (1-cycle synchronous read).

Parameters:
ADDR_W, 14, address width of frame memory and both requester ports
DATA_W, 8, pixel/data width
MEM_DEPTH, 10003, valid addresses 0..MEM_DEPTH-1; higher addresses are out of range
WAIT_W, 16, width of saturating processor stall counter

Ports:
vga_clk  in  1  single clock for all logic
rst  in  1  asynchronous active-low reset
disp_req  in  1  display read request this cycle
disp_addr  in  ADDR_W  display read address
disp_data  out  DATA_W  display read data; combinational copy of ram_rdata
disp_valid  out  1  disp_data valid (registered disp_req, 1 cycle later)
cpu_valid  in  1  processor request valid
cpu_ready  out  1  request slot empty; transfer occurs when cpu_valid && cpu_ready
cpu_we  in  1  1 = write, 0 = read (sampled at transfer)
cpu_addr  in  ADDR_W  processor address (sampled at transfer)
cpu_wdata  in  DATA_W  write data (sampled at transfer)
cpu_rdata  out  DATA_W  registered read data
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_err  out  1  sticky out-of-range access flag
cpu_stall  out  WAIT_W  cycles the current/last request waited for the RAM, saturating
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Slot is cleared.
  - These outputs are 0: disp_valid, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall.
  - cpu_ready = 1 once reset is released.
  - ram_we = 0 while rst is low and in the first cycle after release.
- RAM port mux (combinational):
  - If disp_req: ram_addr = disp_addr, ram_we = 0.
  - Else if state == PEND: ram_addr = slot address, ram_we = slot we and in-range.
  - Else: ram_addr = 0, ram_we = 0.
  - ram_wdata = slot data at all times.
- disp_valid <= disp_req every cycle. The display path carries no state dependence.
- FSM states:
  - IDLE:
    - cpu_ready = 1.
    - On transfer: capture we/addr/wdata into the slot, set cpu_stall to 0, go to PEND.
  - PEND:
    - cpu_ready = 0.
    - If disp_req: stay in PEND, cpu_stall += 1, saturating at all ones.
    - Else, in-range write: issue the write, go to IDLE.
    - Else, in-range read: issue the read, go to RDWAIT.
    - Else, out of range: no RAM access, set cpu_err, go to IDLE for a write or to RDWAIT for a read (forced zero data).
  - RDWAIT:
    - cpu_ready = 0.
    - cpu_rdata <= ram_rdata, or 0 if the access was out of range.
    - cpu_rvalid <= 1 (high for exactly the next cycle). Go to IDLE.
- Timing:
  - Read latency with no contention: transfer at edge T0, issue during cycle T0+1, cpu_rvalid high during cycle T0+3.
  - A write is committed to RAM in the cycle it is issued.
  - A new transfer is accepted in the cycle cpu_rvalid is high.
- No back-pressure on the display path. A processor starved indefinitely waits indefinitely; cpu_stall saturates and does not wrap.
- cpu_err is cleared only by reset.
- Reset during PEND or RDWAIT:
  - The pending request is discarded.
  - No write is issued and no cpu_rvalid pulse is produced.

Test Plan:
- Reset then idle: after rst released, cpu_ready=1, ram_we=0, all status outputs 0; assert rst low mid-PEND write to 0x0010 -> no RAM write ever seen.
- Uncontended write/read: write 0x5A to 0x0003, then read 0x0003 -> ram_we pulse 1 cycle with addr 0x0003; cpu_rvalid at T0+3 with cpu_rdata=0x5A; cpu_stall=0.
- Contention: hold disp_req high for 20 cycles while processor writes 0xFF to 0x0100 -> write issued on first cycle disp_req low; cpu_stall=20; display reads get disp_valid one cycle after each disp_req with correct data.
- Back-to-back: issue read 0x0004 then write to 0x0005 in the cpu_rvalid cycle -> second transfer accepted that cycle; no request lost or duplicated.
- Out of range: write to 10003, read from 0x3FFF -> no RAM write; read returns cpu_rdata=0 with cpu_rvalid; cpu_err=1 and stays 1.
- Stall saturation: WAIT_W=4, disp_req held 30 cycles -> cpu_stall stops at 15, request completes after disp_req drops.
